// File: rtl/mux3_arbiter_pkg.sv
// Shared definitions for the three-way round-robin mux arbiter:
// state encoding, requester indices and the arbitration helpers.
package mux3_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [1:0] REQ0 = 2'd0;
  localparam logic [1:0] REQ1 = 2'd1;
  localparam logic [1:0] REQ2 = 2'd2;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Step a requester index forward, wrapping 2 back to 0.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == REQ2) ? REQ0 : x + 2'd1;
  endfunction

  // First set request bit scanning ptr, ptr+1, ptr+2 (mod 3).
  function automatic rr_pick_t next_rr(input logic [2:0] req, input logic [1:0] ptr);
    rr_pick_t   pick;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    c0 = ptr;
    c1 = inc3(c0);
    c2 = inc3(c1);
    pick.found = 1'b0;
    pick.idx   = REQ0;
    if (req[c0]) begin
      pick.found = 1'b1;
      pick.idx   = c0;
    end else if (req[c1]) begin
      pick.found = 1'b1;
      pick.idx   = c1;
    end else if (req[c2]) begin
      pick.found = 1'b1;
      pick.idx   = c2;
    end
    return pick;
  endfunction

  // One-hot grant vector for a requester index.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/mux3_arbiter_m3_1.sv
// Plain 3:1 word mux; select value 3 never occurs and falls back to input 0.
module m3_1
  import mux3_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       s_i,
  input  logic [WIDTH-1:0] i0_i,
  input  logic [WIDTH-1:0] i1_i,
  input  logic [WIDTH-1:0] i2_i,
  output logic [WIDTH-1:0] o_o
);

  // Route the selected input straight to the output.
  always_comb begin
    case (s_i)
      REQ1:    o_o = i1_i;
      REQ2:    o_o = i2_i;
      default: o_o = i0_i;
    endcase
  end

endmodule

// File: rtl/mux3_arbiter.sv
// Round-robin arbiter owning the shared 3:1 mux select. An owner keeps the
// grant until it drops its request, strobes DONE, or the hold timer expires;
// release and the next grant happen on the same edge.
module mux3_arbiter
  import mux3_arbiter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       REQ,
  input  logic [2:0]       DONE,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  output logic [2:0]       GNT,
  output logic [1:0]       S,
  output logic             VALID,
  output logic [WIDTH-1:0] O,
  output logic             TIMEOUT
);

  localparam int            TW          = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [TW-1:0] HOLD_T      = TW'(HOLD_MAX);
  localparam logic [TW-1:0] TIMER_MAX   = '1;
  localparam bit            HAS_TIMEOUT = (HOLD_MAX != 0);

  logic [0:0]    state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;

  rr_pick_t   idlePick;
  rr_pick_t   handPick;
  logic [1:0] nextPtr;
  logic       ownDone;
  logic       ownReq;
  logic       expired;
  logic       release_;

  assign nextPtr  = inc3(sel_q);
  assign idlePick = next_rr(REQ, ptr_q);
  assign handPick = next_rr(REQ, nextPtr);
  assign ownDone  = DONE[sel_q];
  assign ownReq   = REQ[sel_q];
  assign expired  = HAS_TIMEOUT && (timer_q == HOLD_T);
  assign release_ = ownDone || !ownReq || expired;

  // Next-state logic: arbitrate from idle, or hold / release / hand off in grant.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (idlePick.found) begin
          state_d = ST_GRANT;
          gnt_d   = onehot3(idlePick.idx);
          sel_d   = idlePick.idx;
          timer_d = TW'(1);
        end
      end
      default: begin
        if (release_) begin
          ptr_d     = nextPtr;
          timeout_d = expired && !ownDone && ownReq;
          if (handPick.found) begin
            gnt_d   = onehot3(handPick.idx);
            sel_d   = handPick.idx;
            timer_d = TW'(1);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 3'b000;
            timer_d = '0;
          end
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  // State registers with synchronous reset; S is kept while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 3'b000;
      sel_q     <= REQ0;
      ptr_q     <= REQ0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign GNT     = gnt_q;
  assign S       = sel_q;
  assign VALID   = |gnt_q;
  assign TIMEOUT = timeout_q;

  m3_1 #(.WIDTH(WIDTH)) u_mux (
    .s_i  (sel_q),
    .i0_i (I0),
    .i1_i (I1),
    .i2_i (I2),
    .o_o  (O)
  );

endmodule

// File: tb/tb_mux3_arbiter.sv
// Bench for mux3_arbiter: one instance with a 4-cycle hold limit runs the
// main vector table, a second with a 3-cycle limit covers sole-owner re-grant.
module tb_mux3_arbiter;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       tmo;
    logic       useB;
    string      name;
  } vec_t;

  typedef struct {
    string      name;
    logic       useB;
    logic [2:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       tmo;
    logic [3:0] o;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [2:0] req;
  logic [2:0] done;
  logic [3:0] i0, i1, i2;

  logic [2:0] gntA, gntB;
  logic [1:0] sA, sB;
  logic       validA, validB;
  logic [3:0] oA, oB;
  logic       toA, toB;

  exp_t expQ[$];
  vec_t tbl[31];
  int   vectorCount;
  int   missCount;

  mux3_arbiter #(.WIDTH(4), .HOLD_MAX(4)) dutA (
    .CLK(clock), .RST(reset), .REQ(req), .DONE(done),
    .I0(i0), .I1(i1), .I2(i2),
    .GNT(gntA), .S(sA), .VALID(validA), .O(oA), .TIMEOUT(toA)
  );

  mux3_arbiter #(.WIDTH(4), .HOLD_MAX(3)) dutB (
    .CLK(clock), .RST(reset), .REQ(req), .DONE(done),
    .I0(i0), .I1(i1), .I2(i2),
    .GNT(gntB), .S(sB), .VALID(validB), .O(oB), .TIMEOUT(toB)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] dn,
                              input logic [2:0] g, input logic [1:0] s, input logic v,
                              input logic t, input logic b, input string n);
    vec_t x;
    x.rst = r; x.req = rq; x.done = dn; x.gnt = g; x.s = s;
    x.valid = v; x.tmo = t; x.useB = b; x.name = n;
    return x;
  endfunction

  // Drive one cycle of inputs, queue its expectation, and step past the edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    reset = v.rst;
    req   = v.req;
    done  = v.done;
    i0    = 4'($urandom_range(0, 15));
    i1    = 4'($urandom_range(0, 15));
    i2    = 4'($urandom_range(0, 15));
    e.name  = v.name;
    e.useB  = v.useB;
    e.gnt   = v.gnt;
    e.s     = v.s;
    e.valid = v.valid;
    e.tmo   = v.tmo;
    e.o     = (v.s == 2'd0) ? i0 : (v.s == 2'd1) ? i1 : i2;
    expQ.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the chosen instance.
  task automatic checkOutput();
    exp_t       e;
    logic [11:0] got;
    logic [11:0] want;
    if (expQ.size() == 0) begin
      missCount++;
      $display("[TB] FAIL scoreboard-empty: got no expectation, required one queued");
      return;
    end
    e = expQ.pop_front();
    vectorCount++;
    got  = e.useB ? {gntB, sB, validB, toB, oB} : {gntA, sA, validA, toA, oA};
    want = {e.gnt, e.s, e.valid, e.tmo, e.o};
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got gnt=%b s=%0d valid=%b timeout=%b o=%h, required gnt=%b s=%0d valid=%b timeout=%b o=%h",
               e.name, got[11:9], got[8:7], got[6], got[5], got[3:0],
               e.gnt, e.s, e.valid, e.tmo, e.o);
    end
  endtask

  // Table walk for the 4-cycle instance, then the sole-owner sequence.
  initial begin
    vectorCount = 0;
    missCount   = 0;
    reset = 1'b1; req = 3'b000; done = 3'b000;
    i0 = 4'h0; i1 = 4'h0; i2 = 4'h0;

    tbl[0]  = mk(1, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0, 0, "reset-1");
    tbl[1]  = mk(1, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0, 0, "reset-2");
    tbl[2]  = mk(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0, 0, "first-grant");
    tbl[3]  = mk(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0, 0, "rr-hold0");
    tbl[4]  = mk(0, 3'b111, 3'b001, 3'b010, 2'd1, 1, 0, 0, "rr-to1");
    tbl[5]  = mk(0, 3'b111, 3'b000, 3'b010, 2'd1, 1, 0, 0, "rr-hold1");
    tbl[6]  = mk(0, 3'b111, 3'b010, 3'b100, 2'd2, 1, 0, 0, "rr-to2");
    tbl[7]  = mk(0, 3'b111, 3'b000, 3'b100, 2'd2, 1, 0, 0, "rr-hold2");
    tbl[8]  = mk(0, 3'b111, 3'b100, 3'b001, 2'd0, 1, 0, 0, "rr-to0");
    tbl[9]  = mk(0, 3'b011, 3'b000, 3'b001, 2'd0, 1, 0, 0, "tmo-hold2");
    tbl[10] = mk(0, 3'b011, 3'b000, 3'b001, 2'd0, 1, 0, 0, "tmo-hold3");
    tbl[11] = mk(0, 3'b011, 3'b000, 3'b001, 2'd0, 1, 0, 0, "tmo-hold4");
    tbl[12] = mk(0, 3'b011, 3'b000, 3'b010, 2'd1, 1, 1, 0, "tmo-handoff");
    tbl[13] = mk(0, 3'b011, 3'b000, 3'b010, 2'd1, 1, 0, 0, "tmo-pulse-end");
    tbl[14] = mk(0, 3'b011, 3'b001, 3'b010, 2'd1, 1, 0, 0, "done-nonowner");
    tbl[15] = mk(0, 3'b101, 3'b000, 3'b100, 2'd2, 1, 0, 0, "req-drop-handoff");
    tbl[16] = mk(0, 3'b101, 3'b001, 3'b100, 2'd2, 1, 0, 0, "done-ignored-a");
    tbl[17] = mk(0, 3'b101, 3'b011, 3'b100, 2'd2, 1, 0, 0, "done-ignored-b");
    tbl[18] = mk(0, 3'b101, 3'b000, 3'b100, 2'd2, 1, 0, 0, "owner2-hold4");
    tbl[19] = mk(0, 3'b101, 3'b100, 3'b001, 2'd0, 1, 0, 0, "done-on-timeout");
    tbl[20] = mk(0, 3'b101, 3'b000, 3'b001, 2'd0, 1, 0, 0, "owner0-hold");
    tbl[21] = mk(0, 3'b111, 3'b001, 3'b010, 2'd1, 1, 0, 0, "ptr-advance");
    tbl[22] = mk(1, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0, 0, "reset-midgrant");
    tbl[23] = mk(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0, 0, "ptr-cleared");
    tbl[24] = mk(0, 3'b010, 3'b001, 3'b010, 2'd1, 1, 0, 0, "single-req1");
    tbl[25] = mk(0, 3'b000, 3'b010, 3'b000, 2'd1, 0, 0, 0, "release-idle");
    tbl[26] = mk(0, 3'b000, 3'b111, 3'b000, 2'd1, 0, 0, 0, "done-no-grant");
    tbl[27] = mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 1, 0, 0, "idle-grant2");
    tbl[28] = mk(0, 3'b000, 3'b000, 3'b000, 2'd2, 0, 0, 0, "s-retained");
    tbl[29] = mk(0, 3'b010, 3'b000, 3'b010, 2'd1, 1, 0, 0, "idle-grant1");
    tbl[30] = mk(0, 3'b010, 3'b010, 3'b010, 2'd1, 1, 0, 0, "done-sole-regrant");

    @(negedge clock);
    for (int k = 0; k < 31; k++) begin
      applyStimulus(tbl[k]);
      checkOutput();
      @(negedge clock);
    end

    applyStimulus(mk(1, 3'b100, 3'b000, 3'b000, 2'd0, 0, 0, 1, "B-reset"));
    checkOutput();
    @(negedge clock);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 1,
                       (k > 1) && ((k % 3) == 1), 1,
                       $sformatf("B-sole-regrant-%0d", k)));
      checkOutput();
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
